// File: rtl/aesl_deadlock_axis_monitor.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_axis_monitor
//
// Purpose:
//   Deadlock monitor for an AXIS-connected dataflow region. A cycle is a
//   candidate deadlock cycle when at least one AXIS channel is stalled, at
//   least one child instance reports block, and not every instance is idle.
//   After PERSIST consecutive candidate cycles the monitor enters BLOCKED.
//   It then raises block, publishes a per-channel stall snapshot, and counts
//   the entry in a saturating event counter. The block output can feed the
//   inst_block_sigs input of a parent monitor, so monitors can be nested.
//
// Ports:
//   clock            in   1                  rising-edge clock
//   reset            in   1                  asynchronous, active-low reset
//   clear            in   1                  synchronous: leave BLOCKED, zero counter
//   axis_block_sigs  in   NUM_AXIS           per-channel AXIS stall
//   inst_idle_sigs   in   NUM_INST           per-instance idle
//   inst_block_sigs  in   NUM_BLK            per-instance block from child monitors
//   axis_block_info  out  NUM_AXIS*NUM_AXIS  stall snapshot, one field per channel
//   block            out  1                  deadlock detected (registered)
//   evt_count        out  EVT_W              deadlock entries, saturating
//   dbg_state        out  2                  current FSM state (0 IDLE, 1 SUSPECT, 2 BLOCKED)
// ---------------------------------------------------------------------------
module aesl_deadlock_axis_monitor #(
    parameter int NUM_AXIS = 2,
    parameter int NUM_INST = 2,
    parameter int NUM_BLK  = 1,
    parameter int PERSIST  = 1,
    parameter int STICKY   = 0,
    parameter int EVT_W    = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [NUM_AXIS-1:0]            axis_block_sigs,
    input  logic [NUM_INST-1:0]            inst_idle_sigs,
    input  logic [NUM_BLK-1:0]             inst_block_sigs,
    output logic [NUM_AXIS*NUM_AXIS-1:0]   axis_block_info,
    output logic                           block,
    output logic [EVT_W-1:0]               evt_count,
    output logic [1:0]                     dbg_state
);

    localparam int PCNT_W = $clog2(PERSIST + 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    // Last SUSPECT count before BLOCKED; only reachable when PERSIST > 1.
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERSIST - 1);
    localparam logic [EVT_W-1:0]  EVT_ONE   = EVT_W'(1);
    localparam logic [EVT_W-1:0]  EVT_MAX   = {EVT_W{1'b1}};
    localparam int INFO_W = NUM_AXIS * NUM_AXIS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q,  pcnt_d;
    logic [INFO_W-1:0]   info_q,  info_d;
    logic [EVT_W-1:0]    evt_q,   evt_d;
    logic                block_q, block_d;

    logic                cand;
    logic                enter_blocked;
    logic [INFO_W-1:0]   snap;

    assign cand = (|axis_block_sigs) & (|inst_block_sigs) & ~(&inst_idle_sigs);

    // Stall snapshot: a stalled channel i loads the all-ones field with bit i
    // cleared; an unstalled channel loads zero.
    always_comb begin
        snap = '0;
        for (int i = 0; i < NUM_AXIS; i++) begin
            if (axis_block_sigs[i]) begin
                snap[i*NUM_AXIS +: NUM_AXIS] = ~(NUM_AXIS'(1) << i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        info_d        = info_q;
        evt_d         = evt_q;
        enter_blocked = 1'b0;

        if (clear) begin
            // clear has priority over a candidate cycle in every state.
            state_d = ST_IDLE;
            pcnt_d  = '0;
            info_d  = '0;
            evt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cand) begin
                        if (PERSIST == 1) begin
                            enter_blocked = 1'b1;
                        end else begin
                            state_d = ST_SUSPECT;
                            pcnt_d  = PCNT_ONE;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!cand) begin
                        state_d = ST_IDLE;
                        pcnt_d  = '0;
                    end else if (pcnt_q == PCNT_LAST) begin
                        enter_blocked = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_ONE;
                    end
                end
                ST_BLOCKED: begin
                    if ((STICKY == 0) && !cand) begin
                        state_d = ST_IDLE;
                        info_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                    info_d  = '0;
                end
            endcase

            if (enter_blocked) begin
                state_d = ST_BLOCKED;
                pcnt_d  = '0;
                info_d  = snap;
                if (evt_q != EVT_MAX) begin
                    evt_d = evt_q + EVT_ONE;
                end
            end
        end

        block_d = (state_d == ST_BLOCKED);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            info_q  <= '0;
            evt_q   <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            info_q  <= info_d;
            evt_q   <= evt_d;
            block_q <= block_d;
        end
    end

    assign block           = block_q;
    // The snapshot is only visible while block is high.
    assign axis_block_info = block_q ? info_q : '0;
    assign evt_count       = evt_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_aesl_deadlock_axis_monitor.sv
// ---------------------------------------------------------------------------
// tb_aesl_deadlock_axis_monitor
//
// Four monitor instances share one stimulus stream, each with a different
// parameter set:
//   u0: PERSIST=1 STICKY=0 EVT_W=8
//   u1: PERSIST=4 STICKY=0 EVT_W=8
//   u2: PERSIST=2 STICKY=1 EVT_W=8
//   u3: PERSIST=1 STICKY=0 EVT_W=2
// The reference model tracks the length of the current run of candidate
// cycles; a monitor is blocked once that run reaches PERSIST (sticky
// instances stay blocked until clear).
// ---------------------------------------------------------------------------
module tb_aesl_deadlock_axis_monitor;

    logic       clock;
    logic       reset;
    logic       clear;
    logic [1:0] axis_sigs;
    logic [1:0] idle_sigs;
    logic [0:0] blk_sigs;

    logic       blk_o  [4];
    logic [3:0] info_o [4];
    logic [7:0] evt_o  [4];
    logic [1:0] dbg_o  [4];

    logic [7:0] evt0, evt1, evt2;
    logic [1:0] evt3;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT instances ----------------
    aesl_deadlock_axis_monitor #(.NUM_AXIS(2), .NUM_INST(2), .NUM_BLK(1),
        .PERSIST(1), .STICKY(0), .EVT_W(8)) u0 (
        .clock(clock), .reset(reset), .clear(clear),
        .axis_block_sigs(axis_sigs), .inst_idle_sigs(idle_sigs),
        .inst_block_sigs(blk_sigs), .axis_block_info(info_o[0]),
        .block(blk_o[0]), .evt_count(evt0), .dbg_state(dbg_o[0]));

    aesl_deadlock_axis_monitor #(.NUM_AXIS(2), .NUM_INST(2), .NUM_BLK(1),
        .PERSIST(4), .STICKY(0), .EVT_W(8)) u1 (
        .clock(clock), .reset(reset), .clear(clear),
        .axis_block_sigs(axis_sigs), .inst_idle_sigs(idle_sigs),
        .inst_block_sigs(blk_sigs), .axis_block_info(info_o[1]),
        .block(blk_o[1]), .evt_count(evt1), .dbg_state(dbg_o[1]));

    aesl_deadlock_axis_monitor #(.NUM_AXIS(2), .NUM_INST(2), .NUM_BLK(1),
        .PERSIST(2), .STICKY(1), .EVT_W(8)) u2 (
        .clock(clock), .reset(reset), .clear(clear),
        .axis_block_sigs(axis_sigs), .inst_idle_sigs(idle_sigs),
        .inst_block_sigs(blk_sigs), .axis_block_info(info_o[2]),
        .block(blk_o[2]), .evt_count(evt2), .dbg_state(dbg_o[2]));

    aesl_deadlock_axis_monitor #(.NUM_AXIS(2), .NUM_INST(2), .NUM_BLK(1),
        .PERSIST(1), .STICKY(0), .EVT_W(2)) u3 (
        .clock(clock), .reset(reset), .clear(clear),
        .axis_block_sigs(axis_sigs), .inst_idle_sigs(idle_sigs),
        .inst_block_sigs(blk_sigs), .axis_block_info(info_o[3]),
        .block(blk_o[3]), .evt_count(evt3), .dbg_state(dbg_o[3]));

    assign evt_o[0] = evt0;
    assign evt_o[1] = evt1;
    assign evt_o[2] = evt2;
    assign evt_o[3] = {6'b0, evt3};

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] run;   // length of current candidate run
        logic        blk;
        logic [3:0]  info;
        logic [7:0]  evt;
    } mst_t;

    mst_t m_st [4];

    function automatic int p_of(input int k);
        case (k)
            1:       return 4;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit sticky_of(input int k);
        return (k == 2);
    endfunction

    function automatic int evt_max_of(input int k);
        return (k == 3) ? 3 : 255;
    endfunction

    // Channel 0 stalled -> field0 = 2'b10; channel 1 stalled -> field1 = 2'b01.
    function automatic logic [3:0] snap_of(input logic [1:0] a);
        logic [1:0] f0;
        logic [1:0] f1;
        f0 = a[0] ? 2'b10 : 2'b00;
        f1 = a[1] ? 2'b01 : 2'b00;
        return {f1, f0};
    endfunction

    function automatic mst_t model_next(input int k, input mst_t cur,
                                        input logic [1:0] a, input logic [1:0] id,
                                        input logic b, input logic c);
        mst_t n;
        bit   cand;
        n    = cur;
        cand = (a != 2'b00) && b && (id != 2'b11);
        if (c) begin
            n.run  = 0;
            n.blk  = 1'b0;
            n.info = 4'h0;
            n.evt  = 8'h0;
            return n;
        end
        n.run = cand ? cur.run + 1 : 0;
        if (sticky_of(k)) n.blk = cur.blk || (n.run >= 32'(p_of(k)));
        else              n.blk = (n.run >= 32'(p_of(k)));
        if (n.blk && !cur.blk) begin
            n.info = snap_of(a);
            if (int'(cur.evt) < evt_max_of(k)) n.evt = cur.evt + 8'd1;
        end
        if (!n.blk) n.info = 4'h0;
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) m_st[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                m_st[k] <= model_next(k, m_st[k], axis_sigs, idle_sigs, blk_sigs[0], clear);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("u%0d block", k), 32'(blk_o[k]),  32'(m_st[k].blk));
                chk($sformatf("u%0d info", k),  32'(info_o[k]), 32'(m_st[k].info));
                chk($sformatf("u%0d evt", k),   32'(evt_o[k]),  32'(m_st[k].evt));
            end
        end
    end

    // ---------------- driver ----------------
    // Apply inputs for n rising edges; return just after the following falling edge.
    task automatic drive(input logic [1:0] a, input logic [1:0] id,
                         input logic b, input logic c, input int n);
        axis_sigs = a;
        idle_sigs = id;
        blk_sigs  = b;
        clear     = c;
        repeat (n) @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic quiet(input int n);
        drive(2'b00, 2'b00, 1'b0, 1'b0, n);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        axis_sigs = 2'b00;
        idle_sigs = 2'b00;
        blk_sigs  = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        quiet(1);
        chk("reset u0 block", 32'(blk_o[0]), 32'd0);
        chk("reset u0 evt",   32'(evt_o[0]), 32'd0);

        // All instances idle: never a deadlock.
        drive(2'b11, 2'b11, 1'b1, 1'b0, 10);
        chk("all idle u0 block", 32'(blk_o[0]), 32'd0);
        chk("all idle u0 evt",   32'(evt_o[0]), 32'd0);
        chk("all idle u1 block", 32'(blk_o[1]), 32'd0);

        // One candidate cycle: PERSIST=1 blocks on the next edge.
        drive(2'b10, 2'b01, 1'b1, 1'b0, 1);
        chk("p1 block", 32'(blk_o[0]),  32'd1);
        chk("p1 info",  32'(info_o[0]), 32'h4);
        chk("p1 evt",   32'(evt_o[0]),  32'd1);
        chk("p2 one cycle block", 32'(blk_o[2]), 32'd0);
        quiet(1);
        chk("p1 release block", 32'(blk_o[0]),  32'd0);
        chk("p1 release info",  32'(info_o[0]), 32'h0);

        // Three candidate cycles: PERSIST=4 stays clear, sticky PERSIST=2 latches.
        drive(2'b01, 2'b00, 1'b1, 1'b0, 3);
        chk("p4 3 cycles block", 32'(blk_o[1]),  32'd0);
        chk("ch0 info",          32'(info_o[0]), 32'h2);
        chk("p1 evt second",     32'(evt_o[0]),  32'd2);
        quiet(1);
        chk("p4 gap block",      32'(blk_o[1]), 32'd0);
        chk("sticky hold block", 32'(blk_o[2]), 32'd1);
        chk("sticky hold evt",   32'(evt_o[2]), 32'd1);

        // Four candidate cycles: PERSIST=4 blocks on the 4th edge.
        drive(2'b11, 2'b10, 1'b1, 1'b0, 3);
        chk("p4 3rd edge block", 32'(blk_o[1]), 32'd0);
        drive(2'b11, 2'b10, 1'b1, 1'b0, 1);
        chk("p4 4th edge block", 32'(blk_o[1]),  32'd1);
        chk("p4 info both",      32'(info_o[1]), 32'h6);
        chk("p4 evt",            32'(evt_o[1]),  32'd1);
        chk("ew2 evt sat",       32'(evt_o[3]),  32'd3);
        quiet(1);
        chk("p4 release", 32'(blk_o[1]), 32'd0);

        // clear together with a candidate cycle: clear wins.
        drive(2'b10, 2'b01, 1'b1, 1'b1, 1);
        chk("clear sticky block", 32'(blk_o[2]), 32'd0);
        chk("clear sticky evt",   32'(evt_o[2]), 32'd0);
        chk("clear u0 block",     32'(blk_o[0]), 32'd0);
        chk("clear u0 evt",       32'(evt_o[0]), 32'd0);
        quiet(1);

        // Five separate single-cycle episodes.
        for (int e = 0; e < 5; e++) begin
            drive(2'b01, 2'b01, 1'b1, 1'b0, 1);
            quiet(1);
        end
        chk("ew2 five episodes evt", 32'(evt_o[3]), 32'd3);
        chk("ew8 five episodes evt", 32'(evt_o[0]), 32'd5);
        chk("gapped p2 block",       32'(blk_o[2]), 32'd0);
        chk("gapped p2 evt",         32'(evt_o[2]), 32'd0);

        // Enter BLOCKED everywhere, then reset asynchronously between edges.
        drive(2'b11, 2'b00, 1'b1, 1'b0, 4);
        chk("pre reset u1 block", 32'(blk_o[1]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("async rst u%0d block", k), 32'(blk_o[k]),  32'd0);
            chk($sformatf("async rst u%0d info", k),  32'(info_o[k]), 32'h0);
            chk($sformatf("async rst u%0d evt", k),   32'(evt_o[k]),  32'd0);
        end
        @(negedge clock);
        #1;
        reset = 1'b1;

        // Mixed vectors after reset.
        drive(2'b01, 2'b10, 1'b1, 1'b0, 2);
        chk("post reset p2 block", 32'(blk_o[2]),  32'd1);
        chk("post reset p2 info",  32'(info_o[2]), 32'h2);
        drive(2'b10, 2'b10, 1'b0, 1'b0, 2);
        chk("no child block u0", 32'(blk_o[0]), 32'd0);
        quiet(3);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
